// File: rtl/adder_axis_accum_if.sv
// AXI-Stream beat bundle shared by the accumulator's input and output.
`timescale 1ns/1ps
interface adder_axis_accum_if #(
    parameter int W = 9
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/adder_axis_accum.sv
// Sums each group of ACC_LEN input beats into one registered total.
`timescale 1ns/1ps
module adder_axis_accum #(
    parameter int  IN_WIDTH  = 9,
    parameter int  ACC_LEN   = 4,
    localparam int CW        = $clog2(ACC_LEN),
    localparam int OUT_WIDTH = IN_WIDTH + CW
) (
    input  logic                aclk,
    input  logic                areset,
    adder_axis_accum_if.slave   data_i,
    adder_axis_accum_if.master  data_o,
    output logic [CW-1:0]       grp_cnt_o
);

    generate
        if (ACC_LEN < 2) begin : g_bad_len
            $error("ACC_LEN must be at least 2");
        end
    endgenerate

    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] tot_q, tot_d;
    logic                 vld_q, vld_d;

    logic                 last_beat;
    logic                 first_beat;
    logic                 in_rdy;
    logic                 hs_in;
    logic                 hs_out;
    logic [OUT_WIDTH-1:0] beat_ext;
    logic [OUT_WIDTH-1:0] sum;

    assign last_beat  = (cnt_q == LAST);
    assign first_beat = (cnt_q == '0);

    // Only the closing beat waits for the output slot to free up.
    assign in_rdy   = !(last_beat && vld_q && !data_o.tready);
    assign hs_in    = data_i.tvalid && in_rdy;
    assign hs_out   = vld_q && data_o.tready;
    assign beat_ext = OUT_WIDTH'(data_i.tdata);
    assign sum      = acc_q + beat_ext;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        tot_d = tot_q;
        vld_d = vld_q;
        if (hs_out) begin
            vld_d = 1'b0;
        end
        if (hs_in) begin
            unique case (1'b1)
                first_beat: begin
                    acc_d = beat_ext;
                    cnt_d = cnt_q + CW'(1);
                end
                last_beat: begin
                    tot_d = sum;
                    vld_d = 1'b1;
                    cnt_d = '0;
                end
                default: begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
            acc_q <= '0;
            tot_q <= '0;
            vld_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            tot_q <= tot_d;
            vld_q <= vld_d;
        end
    end

    assign data_i.tready = in_rdy;
    assign data_o.tvalid = vld_q;
    assign data_o.tdata  = tot_q;
    assign grp_cnt_o     = cnt_q;

endmodule

// File: tb/tb_adder_axis_accum.sv
// Self-checking bench for adder_axis_accum: vector table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_adder_axis_accum;

    localparam int IW = 9;
    localparam int AL = 4;
    localparam int OW = IW + $clog2(AL);

    logic                   aclk = 1'b0;
    logic                   areset = 1'b1;
    logic [$clog2(AL)-1:0]  grp_cnt;

    adder_axis_accum_if #(.W(IW)) in_if ();
    adder_axis_accum_if #(.W(OW)) out_if ();

    adder_axis_accum #(
        .IN_WIDTH (IW),
        .ACC_LEN  (AL)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .data_i    (in_if),
        .data_o    (out_if),
        .grp_cnt_o (grp_cnt)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: beats counted per group, totals queued in order.
    int beat_cnt = 0;
    int grp_sum  = 0;
    int exp_q[$];
    bit stall_q  = 1'b0;
    int hold_q   = 0;

    always @(posedge areset) begin
        exp_q.delete();
        beat_cnt = 0;
        grp_sum  = 0;
        stall_q  = 1'b0;
    end

    always @(negedge aclk) begin
        if (!areset) begin
            chk("grp_cnt", int'(grp_cnt), beat_cnt);
            chk("in_ready", int'(in_if.tready),
                int'(!(beat_cnt == AL-1 && out_if.tvalid && !out_if.tready)));
            if (stall_q && out_if.tvalid)
                chk("hold", int'(out_if.tdata), hold_q);
            if (out_if.tvalid && out_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: got total %0d expected none", out_if.tdata);
                end else begin
                    chk("total", int'(out_if.tdata), exp_q.pop_front());
                end
            end
            if (in_if.tvalid && in_if.tready) begin
                grp_sum += int'(in_if.tdata);
                beat_cnt++;
                if (beat_cnt == AL) begin
                    exp_q.push_back(grp_sum);
                    beat_cnt = 0;
                    grp_sum  = 0;
                end
            end
            stall_q = out_if.tvalid && !out_if.tready;
            hold_q  = int'(out_if.tdata);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the handshake edge.
    task automatic send(input int v);
        int n;
        n = 0;
        in_if.tdata  = IW'(v);
        in_if.tvalid = 1'b1;
        @(negedge aclk);
        while (!in_if.tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no tready expected handshake");
        end
        tick();
        in_if.tvalid = 1'b0;
    endtask

    typedef struct {
        int b0, b1, b2, b3;
        int tot;
    } vec_t;

    vec_t tbl[6];
    bit   drv_done;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 2, 3, 4, 10};
        tbl[1] = '{510, 510, 510, 510, 2040};
        tbl[2] = '{0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0};
        tbl[4] = '{5, 100, 200, 300, 605};
        tbl[5] = '{511, 0, 511, 1, 1023};

        in_if.tdata   = '0;
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;

        #3;
        chk("rst_tvalid", int'(out_if.tvalid), 0);
        chk("rst_tdata", int'(out_if.tdata), 0);
        chk("rst_cnt", int'(grp_cnt), 0);
        chk("rst_tready", int'(in_if.tready), 1);
        #24;
        areset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].b0);
            send(tbl[i].b1);
            send(tbl[i].b2);
            send(tbl[i].b3);
            @(negedge aclk);
            chk("vec_tvalid", int'(out_if.tvalid), 1);
            chk("vec_tdata", int'(out_if.tdata), tbl[i].tot);
            tick();
        end

        // Back-pressure, then drain and load on the same edge.
        out_if.tready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(1);
            end
            begin
                repeat (14) @(negedge aclk);
                chk("bp_tvalid", int'(out_if.tvalid), 1);
                chk("bp_tdata", int'(out_if.tdata), 4);
                chk("bp_cnt", int'(grp_cnt), 3);
                chk("bp_in_ready", int'(in_if.tready), 0);
                tick();
                out_if.tready = 1'b1;
                @(negedge aclk);
                chk("dl_in_ready", int'(in_if.tready), 1);
                tick();
                @(negedge aclk);
                chk("dl_tvalid", int'(out_if.tvalid), 1);
                chk("dl_tdata", int'(out_if.tdata), 4);
            end
        join
        tick();
        tick();
        chk("bp_drained", exp_q.size(), 0);

        // Reset mid-group with a total still pending.
        out_if.tready = 1'b0;
        send(1);
        send(2);
        send(3);
        send(4);
        send(7);
        send(7);
        #2;
        areset = 1'b1;
        #1;
        chk("mr_tvalid", int'(out_if.tvalid), 0);
        chk("mr_tdata", int'(out_if.tdata), 0);
        chk("mr_cnt", int'(grp_cnt), 0);
        chk("mr_tready", int'(in_if.tready), 1);
        #3;
        areset = 1'b0;
        out_if.tready = 1'b1;
        tick();
        send(1);
        send(1);
        send(1);
        send(1);
        @(negedge aclk);
        chk("mr_next_tvalid", int'(out_if.tvalid), 1);
        chk("mr_next_tdata", int'(out_if.tdata), 4);
        tick();

        // Random traffic on both sides.
        drv_done = 1'b0;
        fork
            begin
                for (int g = 0; g < 1000; g++) begin
                    for (int k = 0; k < AL; k++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send(int'($urandom_range(0, 511)));
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_if.tready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_if.tready = 1'b1;
            end
        join
        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_cnt_idle", int'(grp_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
